// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared OBI data-side types and bridge FSM states
package cv32e40x_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  memtype;
        logic [2:0]  prot;
    } obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_data_resp_t;

    typedef enum logic {
        TRANSPARENT = 1'b0,
        REGISTERED  = 1'b1
    } obi_bridge_state_e;

endpackage

// File: rtl/cv32e40x_data_obi_bridge_if.sv
// rtl/cv32e40x_data_obi_bridge_if.sv - filter-side transfer/response and OBI bus signals of the bridge
interface cv32e40x_data_obi_bridge_if;
    import cv32e40x_pkg::*;

    logic           trans_valid_i;
    logic           trans_ready_o;
    obi_data_req_t  trans_i;
    logic           resp_valid_o;
    obi_data_resp_t resp_o;

    logic           obi_req_o;
    logic           obi_gnt_i;
    logic [31:0]    obi_addr_o;
    logic           obi_we_o;
    logic [3:0]     obi_be_o;
    logic [31:0]    obi_wdata_o;
    logic [1:0]     obi_memtype_o;
    logic [2:0]     obi_prot_o;
    logic           obi_rvalid_i;
    logic [31:0]    obi_rdata_i;
    logic           obi_err_i;

    // Bridge view: master of the OBI bus, consumer of the filter's transfers.
    modport master (
        input  trans_valid_i, trans_i,
        output trans_ready_o, resp_valid_o, resp_o,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        output obi_memtype_o, obi_prot_o,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
    );

    // Environment view: response filter plus the OBI slave.
    modport slave (
        output trans_valid_i, trans_i,
        input  trans_ready_o, resp_valid_o, resp_o,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        input  obi_memtype_o, obi_prot_o,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
    );

endinterface

// File: rtl/cv32e40x_obi_outstanding_cnt.sv
// rtl/cv32e40x_obi_outstanding_cnt.sv - saturating-at-zero outstanding transfer counter with spurious-response flag
module cv32e40x_obi_outstanding_cnt #(
    parameter  int unsigned MAX       = 2,
    localparam int unsigned CNT_WIDTH = $clog2(MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up,
    input  logic                 down,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 room,
    output logic                 spurious
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX);

    logic [CNT_WIDTH-1:0] cnt_q;

    assign cnt  = cnt_q;
    assign room = (cnt_q < MAX_CNT);

    // Count grants up and responses down; a response with nothing outstanding holds at zero and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            spurious <= 1'b0;
        end else begin
            spurious <= down && !up && (cnt_q == '0);
            if (up && !down) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end else if (down && !up && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cv32e40x_data_obi_bridge.sv
// rtl/cv32e40x_data_obi_bridge.sv - valid/ready to OBI req/gnt bridge with hold register and outstanding cap
module cv32e40x_data_obi_bridge
    import cv32e40x_pkg::*;
#(
    parameter  int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    cv32e40x_data_obi_bridge_if.master    bus,
    output logic [CNT_WIDTH-1:0]          outstanding_o,
    output logic                          protocol_err_o
);

    obi_bridge_state_e    state_q;
    obi_data_req_t        hold_q;
    obi_data_req_t        attr;
    logic                 req;
    logic                 ready;
    logic                 room;
    logic                 spurious;
    logic [CNT_WIDTH-1:0] cnt;

    // Request and attributes: pass the upstream transfer straight through, or replay the held one
    // until it is granted so the OBI request stays stable.
    always_comb begin
        req   = 1'b0;
        ready = 1'b0;
        attr  = '0;
        if (!rst) begin
            if (state_q == REGISTERED) begin
                req  = 1'b1;
                attr = hold_q;
            end else begin
                req   = bus.trans_valid_i && room;
                ready = room;
                attr  = bus.trans_i;
            end
        end
    end

    assign bus.obi_req_o     = req;
    assign bus.trans_ready_o = ready;
    assign bus.obi_addr_o    = attr.addr;
    assign bus.obi_we_o      = attr.we;
    assign bus.obi_be_o      = attr.be;
    assign bus.obi_wdata_o   = attr.wdata;
    assign bus.obi_memtype_o = attr.memtype;
    assign bus.obi_prot_o    = attr.prot;

    // Responses go straight back to the filter, which always consumes them.
    always_comb begin
        bus.resp_valid_o = 1'b0;
        bus.resp_o       = '0;
        if (!rst) begin
            bus.resp_valid_o = bus.obi_rvalid_i;
            bus.resp_o.rdata = bus.obi_rdata_i;
            bus.resp_o.err   = bus.obi_err_i;
        end
    end

    cv32e40x_obi_outstanding_cnt #(
        .MAX (MAX_OUTSTANDING)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .up       (req && bus.obi_gnt_i),
        .down     (bus.obi_rvalid_i),
        .cnt      (cnt),
        .room     (room),
        .spurious (spurious)
    );

    assign outstanding_o  = rst ? '0 : cnt;
    assign protocol_err_o = !rst && spurious;

    // FSM: an ungranted request is captured into hold_q and replayed until granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRANSPARENT;
            hold_q  <= '0;
        end else begin
            case (state_q)
                TRANSPARENT: begin
                    if (req && !bus.obi_gnt_i) begin
                        hold_q  <= bus.trans_i;
                        state_q <= REGISTERED;
                    end
                end
                REGISTERED: begin
                    if (bus.obi_gnt_i) begin
                        state_q <= TRANSPARENT;
                    end
                end
                default: state_q <= TRANSPARENT;
            endcase
        end
    end

endmodule
